// File: rtl/avmm_cmd_pkg.sv
// Shared types and width helpers for the Avalon-MM command writer.
package avmm_cmd_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } state_t;

  localparam int CMD_ADDR_W = 8;
  localparam int CMD_DATA_W = 32;
  localparam int WR_COUNT_W = 16;

  typedef struct packed {
    logic [CMD_ADDR_W-1:0] address;
    logic [CMD_DATA_W-1:0] writedata;
  } cmd_t;

  function automatic int wait_cnt_w(input int max_wait);
    return $clog2(max_wait + 1);
  endfunction

endpackage

// File: rtl/avmm_cmd_writer_fifo.sv
// Synchronous command FIFO; the extra pointer bit separates full from empty.
module cmd_fifo
  import avmm_cmd_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = cmd_t
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  T     wdata,
  input  logic pop,
  output T     rdata,
  output logic full,
  output logic empty
);

  localparam int PTR_W = $clog2(DEPTH) + 1;

  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  T                 mem_r [DEPTH];
  logic             do_push_s;
  logic             do_pop_s;

  assign empty     = (wr_ptr_r == rd_ptr_r);
  assign full      = (wr_ptr_r[PTR_W-1] != rd_ptr_r[PTR_W-1]) &&
                     (wr_ptr_r[PTR_W-2:0] == rd_ptr_r[PTR_W-2:0]);
  assign do_push_s = push && !full;
  assign do_pop_s  = pop && !empty;
  assign rdata     = mem_r[rd_ptr_r[PTR_W-2:0]];

  // Pointer update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
    end
  end

  // Storage write; contents are don't-care while the FIFO is empty
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r[PTR_W-2:0]] <= wdata;
    end
  end

endmodule

// File: rtl/avmm_cmd_writer.sv
// Avalon-MM write master: buffers {address, data} commands and issues one
// write per command with waitrequest handling and a stall timeout.
module avmm_cmd_writer
  import avmm_cmd_pkg::*;
#(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_WAIT   = 255
) (
  input  logic                  clk,
  input  logic                  reset_reset_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_W-1:0]     cmd_address,
  input  logic [DATA_W-1:0]     cmd_writedata,
  output logic [ADDR_W-1:0]     avm_address,
  output logic                  avm_write,
  output logic [DATA_W-1:0]     avm_writedata,
  input  logic                  avm_waitrequest,
  output logic                  busy,
  output logic [WR_COUNT_W-1:0] wr_count,
  output logic                  timeout_err,
  input  logic                  err_clr
);

  localparam int WAIT_W = wait_cnt_w(MAX_WAIT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

  typedef struct packed {
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] writedata;
  } cmd_w_t;

  state_t              state_r;
  logic [WAIT_W-1:0]   wait_cnt_r;
  cmd_w_t              fifo_in_s;
  cmd_w_t              fifo_out_s;
  logic                fifo_full_s;
  logic                fifo_empty_s;
  logic                push_s;
  logic                pop_s;
  logic                done_s;
  logic                timeout_s;

  assign fifo_in_s = '{address: cmd_address, writedata: cmd_writedata};
  assign cmd_ready = !fifo_full_s;
  assign push_s    = cmd_valid && !fifo_full_s;
  assign busy      = !fifo_empty_s || (state_r == WRITE);

  cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (cmd_w_t)
  ) u_fifo (
    .clk   (clk),
    .rst_n (reset_reset_n),
    .push  (push_s),
    .wdata (fifo_in_s),
    .pop   (pop_s),
    .rdata (fifo_out_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

  // Decode transfer completion, timeout and FIFO pop for this edge
  always_comb begin
    done_s    = 1'b0;
    timeout_s = 1'b0;
    pop_s     = 1'b0;
    case (state_r)
      IDLE: begin
        pop_s = !fifo_empty_s;
      end
      WRITE: begin
        if (!avm_waitrequest) begin
          done_s = 1'b1;
          pop_s  = !fifo_empty_s;
        end else if (wait_cnt_r == WAIT_LAST) begin
          timeout_s = 1'b1;
        end else begin
          timeout_s = 1'b0;
        end
      end
      default: begin
        pop_s = 1'b0;
      end
    endcase
  end

  // FSM and Avalon output registers
  always_ff @(posedge clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_r       <= IDLE;
      wait_cnt_r    <= '0;
      avm_write     <= 1'b0;
      avm_address   <= '0;
      avm_writedata <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (pop_s) begin
            avm_address   <= fifo_out_s.address;
            avm_writedata <= fifo_out_s.writedata;
            avm_write     <= 1'b1;
            wait_cnt_r    <= '0;
            state_r       <= WRITE;
          end else begin
            avm_write <= 1'b0;
          end
        end
        WRITE: begin
          if (done_s && pop_s) begin
            // Back-to-back: next command loads on the completion edge
            avm_address   <= fifo_out_s.address;
            avm_writedata <= fifo_out_s.writedata;
            avm_write     <= 1'b1;
            wait_cnt_r    <= '0;
          end else if (done_s || timeout_s) begin
            avm_write <= 1'b0;
            state_r   <= IDLE;
          end else begin
            wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
          end
        end
        default: begin
          avm_write <= 1'b0;
          state_r   <= IDLE;
        end
      endcase
    end
  end

  // Completed-write counter and sticky timeout flag (set beats clear)
  always_ff @(posedge clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      wr_count    <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (done_s) begin
        wr_count <= wr_count + WR_COUNT_W'(1);
      end else begin
        wr_count <= wr_count;
      end
      if (timeout_s) begin
        timeout_err <= 1'b1;
      end else if (err_clr) begin
        timeout_err <= 1'b0;
      end else begin
        timeout_err <= timeout_err;
      end
    end
  end

endmodule

// File: tb/tb_avmm_cmd_writer.sv
// Self-checking bench for avmm_cmd_writer: scoreboard of accepted commands
// compared against completed Avalon writes, plus per-scenario checks.
module tb_avmm_cmd_writer;

  localparam int MAX_WAIT = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [7:0]  cmd_address = 8'h00;
  logic [31:0] cmd_writedata = 32'h0;
  logic [7:0]  avm_address;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic        avm_waitrequest = 1'b0;
  logic        busy;
  logic [15:0] wr_count;
  logic        timeout_err;
  logic        err_clr = 1'b0;

  typedef struct packed {
    logic [7:0]  a;
    logic [31:0] d;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_cnt = 16'h0;

  avmm_cmd_writer #(
    .ADDR_W(8), .DATA_W(32), .FIFO_DEPTH(4), .MAX_WAIT(MAX_WAIT)
  ) dut (
    .clk(clk), .reset_reset_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_address(cmd_address), .cmd_writedata(cmd_writedata),
    .avm_address(avm_address), .avm_write(avm_write),
    .avm_writedata(avm_writedata), .avm_waitrequest(avm_waitrequest),
    .busy(busy), .wr_count(wr_count), .timeout_err(timeout_err),
    .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  // Scoreboard: every completed write must match the oldest accepted command
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && avm_write && !avm_waitrequest) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write got=%h/%h required=none", avm_address, avm_writedata);
      end else begin
        e = exp_q.pop_front();
        if ({avm_address, avm_writedata} !== {e.a, e.d}) begin
          errors++;
          $display("FAIL write_data got=%h/%h required=%h/%h", avm_address, avm_writedata, e.a, e.d);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a command and wait (bounded) until it is accepted
  task automatic push_cmd(input logic [7:0] a, input logic [31:0] d);
    int n;
    n = 0;
    cmd_valid = 1'b1;
    cmd_address = a;
    cmd_writedata = d;
    while (!cmd_ready && n < 50) begin
      tick();
      n++;
    end
    checks++;
    if (!cmd_ready) begin
      errors++;
      $display("FAIL push_wait got=ready%b required=ready1", cmd_ready);
    end else begin
      exp_q.push_back({a, d});
    end
    tick();
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({avm_write, avm_address, avm_writedata, wr_count, timeout_err, busy} !== 59'h0) begin
      errors++;
      $display("FAIL reset_outputs got=%b%h%h%h%b%b required=all zero",
               avm_write, avm_address, avm_writedata, wr_count, timeout_err, busy);
    end
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release got=ready%b busy%b required=ready1 busy0", cmd_ready, busy);
    end
  endtask

  task automatic test_single();
    avm_waitrequest = 1'b0;
    push_cmd(8'h04, 32'hDEADBEEF);
    cmd_valid = 1'b0;
    checks++;
    if (avm_write !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_queued got=write%b busy%b required=write0 busy1", avm_write, busy);
    end
    tick();
    checks++;
    if (avm_write !== 1'b1 || avm_address !== 8'h04 || avm_writedata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL single_issue got=%b/%h/%h required=1/04/deadbeef", avm_write, avm_address, avm_writedata);
    end
    tick();
    exp_cnt = exp_cnt + 16'd1;
    checks++;
    if (avm_write !== 1'b0 || busy !== 1'b0 || wr_count !== exp_cnt) begin
      errors++;
      $display("FAIL single_done got=write%b busy%b cnt%h required=write0 busy0 cnt%h", avm_write, busy, wr_count, exp_cnt);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] addrs [5];
    for (int i = 0; i < 5; i++) addrs[i] = 8'h50 + 8'(i);
    avm_waitrequest = 1'b1;
    for (int i = 0; i < 5; i++) push_cmd(addrs[i], 32'hA000_0000 + 32'(i));
    checks++;
    if (cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_full got=ready%b required=ready0", cmd_ready);
    end
    cmd_address = 8'hEE;
    cmd_writedata = 32'hBAD0BAD0;
    repeat (2) tick();
    checks++;
    if (cmd_ready !== 1'b0 || avm_address !== addrs[0] || avm_write !== 1'b1) begin
      errors++;
      $display("FAIL b2b_refuse got=ready%b addr%h write%b required=ready0 addr%h write1", cmd_ready, avm_address, avm_write, addrs[0]);
    end
    cmd_valid = 1'b0;
    avm_waitrequest = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (avm_write !== 1'b1 || avm_address !== addrs[i]) begin
        errors++;
        $display("FAIL b2b_order got=write%b addr%h required=write1 addr%h", avm_write, avm_address, addrs[i]);
      end
      tick();
    end
    exp_cnt = exp_cnt + 16'd5;
    checks++;
    if (avm_write !== 1'b0 || wr_count !== exp_cnt || busy !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_done got=write%b cnt%h busy%b ready%b required=write0 cnt%h busy0 ready1", avm_write, wr_count, busy, cmd_ready, exp_cnt);
    end
  endtask

  task automatic test_stall();
    avm_waitrequest = 1'b1;
    push_cmd(8'h10, 32'h12345678);
    cmd_valid = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (avm_write !== 1'b1 || avm_address !== 8'h10 || avm_writedata !== 32'h12345678) begin
        errors++;
        $display("FAIL stall_hold got=%b/%h/%h required=1/10/12345678", avm_write, avm_address, avm_writedata);
      end
      if (i < 3) tick();
    end
    avm_waitrequest = 1'b0;
    tick();
    exp_cnt = exp_cnt + 16'd1;
    checks++;
    if (avm_write !== 1'b0 || wr_count !== exp_cnt || timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL stall_done got=write%b cnt%h err%b required=write0 cnt%h err0", avm_write, wr_count, timeout_err, exp_cnt);
    end
  endtask

  task automatic test_timeout();
    exp_t dropped;
    avm_waitrequest = 1'b1;
    push_cmd(8'h20, 32'h20202020);
    push_cmd(8'h21, 32'h21212121);
    cmd_valid = 1'b0;
    for (int j = 0; j < 8; j++) begin
      checks++;
      if (avm_write !== 1'b1 || avm_address !== 8'h20) begin
        errors++;
        $display("FAIL timeout_hold got=write%b addr%h required=write1 addr20 (edge %0d)", avm_write, avm_address, j);
      end
      tick();
    end
    dropped = exp_q.pop_front();
    checks++;
    if (avm_write !== 1'b0 || timeout_err !== 1'b1 || wr_count !== exp_cnt) begin
      errors++;
      $display("FAIL timeout_abandon got=write%b err%b cnt%h required=write0 err1 cnt%h (dropped %h)", avm_write, timeout_err, wr_count, exp_cnt, dropped.a);
    end
    avm_waitrequest = 1'b0;
    tick();
    checks++;
    if (avm_write !== 1'b1 || avm_address !== 8'h21) begin
      errors++;
      $display("FAIL timeout_next got=write%b addr%h required=write1 addr21", avm_write, avm_address);
    end
    tick();
    exp_cnt = exp_cnt + 16'd1;
    checks++;
    if (avm_write !== 1'b0 || wr_count !== exp_cnt) begin
      errors++;
      $display("FAIL timeout_next_done got=write%b cnt%h required=write0 cnt%h", avm_write, wr_count, exp_cnt);
    end
  endtask

  task automatic test_err_clr();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    checks++;
    if (timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL errclr_plain got=%b required=0", timeout_err);
    end
    avm_waitrequest = 1'b1;
    push_cmd(8'h30, 32'h30303030);
    cmd_valid = 1'b0;
    tick();
    repeat (7) tick();
    err_clr = 1'b1;
    tick();
    void'(exp_q.pop_front());
    checks++;
    if (timeout_err !== 1'b1 || avm_write !== 1'b0) begin
      errors++;
      $display("FAIL errclr_same_edge got=err%b write%b required=err1 write0", timeout_err, avm_write);
    end
    tick();
    err_clr = 1'b0;
    checks++;
    if (timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL errclr_next got=%b required=0", timeout_err);
    end
    avm_waitrequest = 1'b0;
  endtask

  task automatic test_reset_mid_write();
    avm_waitrequest = 1'b1;
    push_cmd(8'h40, 32'h40404040);
    push_cmd(8'h41, 32'h41414141);
    push_cmd(8'h42, 32'h42424242);
    cmd_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    exp_cnt = 16'h0;
    checks++;
    if ({avm_write, avm_address, avm_writedata, wr_count, timeout_err, busy} !== 59'h0) begin
      errors++;
      $display("FAIL reset_mid got=%b%h%h%h%b%b required=all zero",
               avm_write, avm_address, avm_writedata, wr_count, timeout_err, busy);
    end
    tick();
    #2;
    rst_n = 1'b1;
    tick();
    checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_release got=ready%b busy%b required=ready1 busy0", cmd_ready, busy);
    end
    avm_waitrequest = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (avm_write !== 1'b0) begin
        errors++;
        $display("FAIL reset_stale_write got=%b required=0", avm_write);
      end
    end
  endtask

  task automatic test_wrap();
    avm_waitrequest = 1'b0;
    for (int i = 0; i < 65535; i++) push_cmd(8'(i), 32'(i) * 32'd7 + 32'h1);
    cmd_valid = 1'b0;
    repeat (3) tick();
    checks++;
    if (wr_count !== 16'hFFFF || busy !== 1'b0) begin
      errors++;
      $display("FAIL wrap_preload got=cnt%h busy%b required=cntffff busy0", wr_count, busy);
    end
    push_cmd(8'hFF, 32'hFFFF0000);
    cmd_valid = 1'b0;
    repeat (2) tick();
    checks++;
    if (wr_count !== 16'h0000 || avm_write !== 1'b0) begin
      errors++;
      $display("FAIL wrap got=cnt%h write%b required=cnt0000 write0", wr_count, avm_write);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got=%0d required=0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_timeout();
    test_err_clr();
    test_reset_mid_write();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
